// File: rtl/bk_adder_32_pkg.sv
// Shared constants and prefix-tree placement helpers for the 32-bit Brent-Kung adder.
package bk_adder_32_pkg;

    localparam int WIDTH      = 32;
    localparam int LOG2_WIDTH = 5;
    localparam int LEVELS     = 2 * LOG2_WIDTH - 1;

    // Levels 1..LOG2_WIDTH are the up-sweep; the rest are the down-sweep.
    function automatic int node_span(input int lv);
        if (lv <= LOG2_WIDTH) begin
            return 1 << lv;
        end
        return 1 << (LEVELS + 1 - lv);
    endfunction

    function automatic int lo_dist(input int lv);
        return node_span(lv) / 2;
    endfunction

    function automatic bit is_black(input int lv, input int i);
        int s;
        s = node_span(lv);
        if (lv <= LOG2_WIDTH) begin
            return ((i + 1) % s) == 0;
        end
        return (((i + 1) % s) == (s / 2)) && (i >= s);
    endfunction

endpackage

// File: rtl/bk_adder_32_prefix_cell.sv
// Brent-Kung black cell: (g_hi,p_hi) o (g_lo,p_lo).
module bk_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/bk_adder_32.sv
// 32-bit Brent-Kung parallel-prefix adder with a single registered output stage.
module bk_adder_32
    import bk_adder_32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] unused_p;

    logic gl [0:LEVELS][0:WIDTH-1];
    logic pl [0:LEVELS][0:WIDTH-1];

    assign p = a ^ b;
    assign g = a & b;

    // cin folded into bit 0 so every prefix G already includes the carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        if (i == 0) begin : g_bit0
            assign gl[0][i] = g[i] | (p[i] & cin);
        end else begin : g_bitn
            assign gl[0][i] = g[i];
        end
        assign pl[0][i] = p[i];
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (is_black(lv, i)) begin : g_black
                bk_prefix_cell u_cell (
                    .g_hi  (gl[lv-1][i]),
                    .p_hi  (pl[lv-1][i]),
                    .g_lo  (gl[lv-1][i-lo_dist(lv)]),
                    .p_lo  (pl[lv-1][i-lo_dist(lv)]),
                    .g_out (gl[lv][i]),
                    .p_out (pl[lv][i])
                );
            end else begin : g_pass
                assign gl[lv][i] = gl[lv-1][i];
                assign pl[lv][i] = pl[lv-1][i];
            end
        end
    end

    // Final-level group propagates are not needed for carries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_psink
        assign unused_p[i] = pl[LEVELS][i];
    end

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = gl[LEVELS][i];
        end
    end

    assign sum_c = p ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_c;
            cout <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_bk_adder_32.sv
// Self-checking bench for bk_adder_32: directed corner cases plus random vectors vs. a 33-bit add.
module tb_bk_adder_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    int checks;
    int errors;

    logic [32:0] exp_q;
    string       exp_tag;
    bit          have_exp;

    bk_adder_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                     tag, obs[32], obs[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Check the result of the previous cycle, then drive a new vector.
    // glitch pulses rst_n low between edges; it must not affect the result.
    task automatic step(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic vr, input bit glitch, input string tag);
        @(negedge clk);
        if (have_exp) check(exp_tag, {cout, sum}, exp_q);
        a     = va;
        b     = vb;
        cin   = vc;
        rst_n = vr;
        exp_q    = vr ? ({1'b0, va} + {1'b0, vb} + {32'd0, vc}) : 33'd0;
        exp_tag  = tag;
        have_exp = 1'b1;
        if (glitch) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        have_exp = 1'b0;
        exp_q    = '0;
        exp_tag  = "";
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "reset_ignores_inputs");
        step(32'd0,        32'd0,         1'b0, 1'b0, 1'b0, "reset_hold");
        step(32'd5,        32'd7,         1'b0, 1'b1, 1'b0, "first_after_reset");
        step(32'd567,      32'd435,       1'b1, 1'b1, 1'b0, "dir_567_435");
        step(32'd38446,    32'd9354,      1'b0, 1'b1, 1'b0, "dir_38446_9354");
        step(32'd8624345,  32'd33356752,  1'b1, 1'b1, 1'b0, "dir_8624345");
        step(32'd62335808, 32'd3884384,   1'b0, 1'b1, 1'b0, "dir_62335808");
        step(32'hFFFF_FFFF, 32'd0,        1'b1, 1'b1, 1'b0, "wrap_around");
        step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "msb_carry");
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "max_case");
        step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, 1'b0, "alt_full_propagate");
        step(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, "glitch_no_effect");
        step(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0, "mid_stream_reset");
        step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "after_mid_reset");

        for (int n = 0; n < 10000; n++) begin
            step(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 199) != 0), 1'b0, "random");
        end

        @(negedge clk);
        if (have_exp) check(exp_tag, {cout, sum}, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
